// File: rtl/pipe_ctrl_if.sv
// Control bundle between the ex/fetch side and the pipeline sequencer.
// Signal suffixes are from the sequencer's point of view.
interface pipe_ctrl_if #(
   parameter int unsigned CNT_W = 32
);
   logic             jump_en_i;
   logic [31:0]      jump_addr_i;
   logic             hold_ex_i;
   logic             hold_bus_i;
   logic             jump_en_o;
   logic [31:0]      jump_addr_o;
   logic             hold_o;
   logic             flush_o;
   logic             timeout_o;
   logic [CNT_W-1:0] stall_cnt_o;

   modport master (
      output jump_en_i,
      output jump_addr_i,
      output hold_ex_i,
      output hold_bus_i,
      input  jump_en_o,
      input  jump_addr_o,
      input  hold_o,
      input  flush_o,
      input  timeout_o,
      input  stall_cnt_o
   );

   modport slave (
      input  jump_en_i,
      input  jump_addr_i,
      input  hold_ex_i,
      input  hold_bus_i,
      output jump_en_o,
      output jump_addr_o,
      output hold_o,
      output flush_o,
      output timeout_o,
      output stall_cnt_o
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: arbitrates redirects and holds, drives registered
// PC-load, hold and flush controls, plus stall counter and hold watchdog.
module pipe_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned HOLD_TIMEOUT = 1024,
   parameter int unsigned CNT_W        = 32
) (
   input  logic       clk,
   input  logic       rst,
   pipe_ctrl_if.slave bus
);
   localparam int unsigned HC_W = $clog2(HOLD_TIMEOUT + 1);
   localparam int unsigned FC_W = 3;
   localparam logic [HC_W-1:0] HC_MAX  = HC_W'(HOLD_TIMEOUT);
   localparam logic [FC_W-1:0] FC_INIT = FC_W'(FLUSH_CYCLES - 1);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      HOLD  = 2'd1,
      FLUSH = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic             je_q, je_d;
   logic [31:0]      addr_q, addr_d;
   logic             hold_q, hold_d;
   logic             flush_q, flush_d;
   logic             tmo_q, tmo_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic             pend_q, pend_d;
   logic [31:0]      paddr_q, paddr_d;
   logic [FC_W-1:0]  fcnt_q, fcnt_d;
   logic [HC_W-1:0]  hcnt_q, hcnt_d;

   logic jump_req;
   logic hold_req;

   // A redirect kills the ex op, so it masks hold_ex; flushed ex can't jump.
   assign jump_req = bus.jump_en_i & (state_q != FLUSH);
   assign hold_req = bus.hold_bus_i | (bus.hold_ex_i & ~jump_req);

   always_comb begin
      state_d = state_q;
      je_d    = 1'b0;
      addr_d  = addr_q;
      hold_d  = hold_q;
      flush_d = flush_q;
      pend_d  = pend_q;
      paddr_d = paddr_q;
      fcnt_d  = fcnt_q;
      case (state_q)
         RUN, HOLD: begin
            if (hold_req) begin
               hold_d  = 1'b1;
               flush_d = 1'b0;
               state_d = HOLD;
               if (jump_req) begin
                  pend_d  = 1'b1;
                  paddr_d = bus.jump_addr_i;
               end
            end else if (jump_req || pend_q) begin
               je_d    = 1'b1;
               addr_d  = jump_req ? bus.jump_addr_i : paddr_q;
               hold_d  = 1'b0;
               flush_d = 1'b1;
               pend_d  = 1'b0;
               fcnt_d  = FC_INIT;
               state_d = FLUSH;
            end else begin
               hold_d  = 1'b0;
               flush_d = 1'b0;
               state_d = RUN;
            end
         end
         FLUSH: begin
            hold_d = hold_req;
            if (fcnt_q != '0) begin
               fcnt_d  = fcnt_q - FC_W'(1);
               flush_d = 1'b1;
            end else begin
               flush_d = 1'b0;
               state_d = hold_req ? HOLD : RUN;
            end
         end
         default: begin
            hold_d  = 1'b0;
            flush_d = 1'b0;
            pend_d  = 1'b0;
            state_d = RUN;
         end
      endcase
   end

   always_comb begin
      hcnt_d = '0;
      if (hold_q)
         hcnt_d = (hcnt_q == HC_MAX) ? hcnt_q : hcnt_q + HC_W'(1);
      tmo_d   = tmo_q | (hcnt_d == HC_MAX);
      stall_d = stall_q;
      if (hold_q && stall_q != '1)
         stall_d = stall_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= RUN;
         je_q    <= 1'b0;
         addr_q  <= '0;
         hold_q  <= 1'b0;
         flush_q <= 1'b0;
         tmo_q   <= 1'b0;
         stall_q <= '0;
         pend_q  <= 1'b0;
         paddr_q <= '0;
         fcnt_q  <= '0;
         hcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         je_q    <= je_d;
         addr_q  <= addr_d;
         hold_q  <= hold_d;
         flush_q <= flush_d;
         tmo_q   <= tmo_d;
         stall_q <= stall_d;
         pend_q  <= pend_d;
         paddr_q <= paddr_d;
         fcnt_q  <= fcnt_d;
         hcnt_q  <= hcnt_d;
      end
   end

   assign bus.jump_en_o   = je_q;
   assign bus.jump_addr_o = addr_q;
   assign bus.hold_o      = hold_q;
   assign bus.flush_o     = flush_q;
   assign bus.timeout_o   = tmo_q;
   assign bus.stall_cnt_o = stall_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: cycle model plus directed scenarios
// with literal expectations at key points.
module tb_pipe_ctrl;
   localparam int FC = 2;
   localparam int HT = 16;
   localparam int CW = 4;
   localparam int SMAX = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   pipe_ctrl_if #(.CNT_W(CW)) bus ();

   pipe_ctrl #(
      .FLUSH_CYCLES(FC),
      .HOLD_TIMEOUT(HT),
      .CNT_W(CW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   logic        m_je, m_hold, m_flush, m_tmo, m_pv;
   logic [31:0] m_addr, m_pa;
   int          m_stall, m_hrun, m_fleft;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset;
      m_je = 0; m_hold = 0; m_flush = 0; m_tmo = 0; m_pv = 0;
      m_addr = 0; m_pa = 0; m_stall = 0; m_hrun = 0; m_fleft = 0;
   endtask

   // Flush is tracked as cycles remaining; hold/release share one rule set.
   task automatic model_step;
      logic j, hx, hb;
      logic [31:0] a;
      j = bus.jump_en_i; hx = bus.hold_ex_i; hb = bus.hold_bus_i;
      a = bus.jump_addr_i;
      if (m_hold) begin
         if (m_stall < SMAX) m_stall++;
         m_hrun++;
      end else m_hrun = 0;
      if (m_hrun >= HT) m_tmo = 1;
      m_je = 0;
      if (m_fleft > 0) begin
         m_fleft--;
         m_flush = (m_fleft > 0);
         m_hold = hx | hb;
      end else if (hb || (hx && !j)) begin
         m_hold = 1; m_flush = 0;
         if (j) begin m_pv = 1; m_pa = a; end
      end else if (j || m_pv) begin
         m_je = 1; m_addr = j ? a : m_pa; m_pv = 0;
         m_hold = 0; m_flush = 1; m_fleft = FC;
      end else begin
         m_hold = 0; m_flush = 0;
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) model_reset();
         else model_step();
      end
   end

   always @(negedge clk) begin
      chk("m_je",    32'(bus.jump_en_o),   32'(m_je));
      chk("m_addr",  bus.jump_addr_o,      m_addr);
      chk("m_hold",  32'(bus.hold_o),      32'(m_hold));
      chk("m_flush", 32'(bus.flush_o),     32'(m_flush));
      chk("m_tmo",   32'(bus.timeout_o),   32'(m_tmo));
      chk("m_stall", 32'(bus.stall_cnt_o), 32'(m_stall));
   end

   task automatic cyc(input logic j, input logic [31:0] a,
                      input logic hx, input logic hb);
      @(negedge clk);
      bus.jump_en_i = j; bus.jump_addr_i = a;
      bus.hold_ex_i = hx; bus.hold_bus_i = hb;
   endtask

   task automatic look;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
   endtask

   initial begin
      bus.jump_en_i = 0; bus.jump_addr_i = 0;
      bus.hold_ex_i = 0; bus.hold_bus_i = 0;

      // reset with toggling inputs
      for (int i = 0; i < 3; i++)
         cyc(1'($urandom), $urandom, 1'($urandom), 1'($urandom));
      look();
      chk("rst_je",    32'(bus.jump_en_o), 0);
      chk("rst_hold",  32'(bus.hold_o), 0);
      chk("rst_flush", 32'(bus.flush_o), 0);
      chk("rst_addr",  bus.jump_addr_o, 0);
      @(negedge clk);
      rst = 1;
      bus.jump_en_i = 0; bus.jump_addr_i = 0;
      bus.hold_ex_i = 0; bus.hold_bus_i = 0;
      idle(5);
      look();
      chk("idle_stall", 32'(bus.stall_cnt_o), 0);
      chk("idle_hold",  32'(bus.hold_o), 0);

      // redirect
      cyc(1, 32'h100, 0, 0); look();
      chk("rd_je",    32'(bus.jump_en_o), 1);
      chk("rd_addr",  bus.jump_addr_o, 32'h100);
      chk("rd_flush", 32'(bus.flush_o), 1);
      cyc(0, 0, 0, 0); look();
      chk("rd_je2",    32'(bus.jump_en_o), 0);
      chk("rd_flush2", 32'(bus.flush_o), 1);
      cyc(0, 0, 0, 0); look();
      chk("rd_flush3", 32'(bus.flush_o), 0);

      // deferred jump behind fetch-bus hold
      cyc(0, 0, 0, 1);
      cyc(1, 32'h200, 0, 1);
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1); look();
      chk("df_hold", 32'(bus.hold_o), 1);
      chk("df_je0",  32'(bus.jump_en_o), 0);
      cyc(0, 0, 0, 0); look();
      chk("df_je",    32'(bus.jump_en_o), 1);
      chk("df_addr",  bus.jump_addr_o, 32'h200);
      chk("df_flush", 32'(bus.flush_o), 1);
      chk("df_stall", 32'(bus.stall_cnt_o), 4);
      idle(3);

      // jump beats hold_ex
      cyc(1, 32'h300, 1, 0); look();
      chk("pr_je",   32'(bus.jump_en_o), 1);
      chk("pr_addr", bus.jump_addr_o, 32'h300);
      chk("pr_hold", 32'(bus.hold_o), 0);
      idle(3);

      // newest pending wins
      cyc(1, 32'h500, 0, 1);
      cyc(1, 32'h600, 0, 1);
      cyc(0, 0, 0, 0); look();
      chk("nw_addr", bus.jump_addr_o, 32'h600);
      idle(3);

      // jump at release beats pending
      cyc(1, 32'h500, 0, 1);
      cyc(1, 32'h700, 1, 0); look();
      chk("rl_je",   32'(bus.jump_en_o), 1);
      chk("rl_addr", bus.jump_addr_o, 32'h700);
      idle(3);

      // flush and bus hold overlap
      cyc(1, 32'h800, 0, 0);
      cyc(0, 0, 0, 1); look();
      chk("ov_flush", 32'(bus.flush_o), 1);
      chk("ov_hold",  32'(bus.hold_o), 1);
      cyc(0, 0, 0, 0); look();
      chk("ov_flush2", 32'(bus.flush_o), 0);
      chk("ov_hold2",  32'(bus.hold_o), 0);
      idle(2);

      // watchdog, stall saturation
      for (int i = 1; i <= 20; i++) begin
         cyc(0, 0, 1, 0); look();
         if (i == 16) chk("wd_tmo16", 32'(bus.timeout_o), 0);
         if (i == 17) chk("wd_tmo17", 32'(bus.timeout_o), 1);
      end
      idle(2); look();
      chk("wd_sticky", 32'(bus.timeout_o), 1);
      chk("wd_hold",   32'(bus.hold_o), 0);
      chk("sat_stall", 32'(bus.stall_cnt_o), 32'(SMAX));

      // async reset mid-flush
      cyc(1, 32'h900, 0, 0); look();
      chk("ar_flush", 32'(bus.flush_o), 1);
      chk("ar_tmo",   32'(bus.timeout_o), 1);
      #2 rst = 0;
      #1;
      chk("ar_je",    32'(bus.jump_en_o), 0);
      chk("ar_addr",  bus.jump_addr_o, 0);
      chk("ar_flush0", 32'(bus.flush_o), 0);
      chk("ar_tmo0",  32'(bus.timeout_o), 0);
      chk("ar_stall", 32'(bus.stall_cnt_o), 0);
      @(negedge clk);
      rst = 1;
      bus.jump_en_i = 0;
      idle(3);
      @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
